// File: rtl/branch_ctl.sv
// Branch control for the fetch unit: program-state FSM, registered compare flag,
// branch-target LUT and saturating taken-branch counter.
module branch_ctl #(
  parameter int  LUT_DEPTH = 8,
  parameter int  PC_W      = 10,
  parameter int  DATA_W    = 8,
  parameter int  CNT_W     = 16,
  localparam int IDX_W     = $clog2(LUT_DEPTH)
) (
  input  logic              CLK,
  input  logic              Init_n,
  input  logic              Start,
  input  logic              Halt_in,
  input  logic              Cmp_en,
  input  logic [1:0]        Cmp_op,
  input  logic [DATA_W-1:0] Cmp_a,
  input  logic [DATA_W-1:0] Cmp_b,
  input  logic              Br_req,
  input  logic [IDX_W-1:0]  Br_idx,
  input  logic              Lut_we,
  input  logic [IDX_W-1:0]  Lut_waddr,
  input  logic [PC_W-1:0]   Lut_wdata,
  output logic              Branch_en,
  output logic              FLAG_OUT,
  output logic [PC_W-1:0]   Target,
  output logic [1:0]        ProgState,
  output logic [CNT_W-1:0]  Taken_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_EQ = 2'b00,
    OP_NE = 2'b01,
    OP_LT = 2'b10,
    OP_GE = 2'b11
  } cmp_op_e;

  state_e             state_q, state_d;
  logic               flag_q, flag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0]    lut_q [LUT_DEPTH];
  logic               cmp_res;
  logic               run_start;
  logic               rd_ok, wr_ok;

  // Index range checks only exist when the depth leaves unused index codes.
  if (LUT_DEPTH == (1 << IDX_W)) begin : g_full_range
    assign rd_ok = 1'b1;
    assign wr_ok = 1'b1;
  end else begin : g_part_range
    assign rd_ok = (Br_idx    < IDX_W'(LUT_DEPTH));
    assign wr_ok = (Lut_waddr < IDX_W'(LUT_DEPTH));
  end

  always_comb begin
    cmp_res = 1'b0;
    unique case (cmp_op_e'(Cmp_op))
      OP_EQ: cmp_res = (Cmp_a == Cmp_b);
      OP_NE: cmp_res = (Cmp_a != Cmp_b);
      OP_LT: cmp_res = (Cmp_a <  Cmp_b);
      OP_GE: cmp_res = (Cmp_a >= Cmp_b);
      default: cmp_res = 1'b0;
    endcase
  end

  // Branch_en and Target are combinational so fetch samples them on this edge.
  assign Branch_en = Br_req && (state_q == RUN);
  assign Target    = rd_ok ? lut_q[Br_idx] : '0;
  assign FLAG_OUT  = flag_q;
  assign ProgState = state_q;
  assign Taken_cnt = cnt_q;

  assign run_start = (state_q == HALTED) && Start;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:    if (Start)   state_d = RUN;
      RUN:     if (Halt_in) state_d = HALTED;
      HALTED:  if (Start)   state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (run_start) begin
      flag_d = 1'b0;
      cnt_d  = '0;
    end else begin
      if (Cmp_en && (state_q == RUN)) flag_d = cmp_res;
      // Uses the pre-edge flag, so a same-cycle compare affects later branches only.
      if (Branch_en && flag_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      state_q <= IDLE;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the LUT is built from resettable flops rather than a RAM macro because
  // every entry must read 0 immediately after reset.
  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (Lut_we && wr_ok) begin
      lut_q[Lut_waddr] <= Lut_wdata;
    end
  end

endmodule

// File: tb/tb_branch_ctl.sv
// Scoreboard bench for branch_ctl: stimulus queues expected outputs per cycle,
// a monitor pops and compares them on the falling edge.
module tb_branch_ctl;

  logic        CLK = 1'b0;
  logic        Init_n;
  logic        Start, Halt_in, Cmp_en, Br_req, Lut_we;
  logic [1:0]  Cmp_op;
  logic [7:0]  Cmp_a, Cmp_b;
  logic [2:0]  Br_idx, Lut_waddr;
  logic [9:0]  Lut_wdata;
  logic        Branch_en, FLAG_OUT;
  logic [9:0]  Target;
  logic [1:0]  ProgState;
  logic [15:0] Taken_cnt;

  branch_ctl dut (
    .CLK(CLK), .Init_n(Init_n), .Start(Start), .Halt_in(Halt_in),
    .Cmp_en(Cmp_en), .Cmp_op(Cmp_op), .Cmp_a(Cmp_a), .Cmp_b(Cmp_b),
    .Br_req(Br_req), .Br_idx(Br_idx), .Lut_we(Lut_we), .Lut_waddr(Lut_waddr),
    .Lut_wdata(Lut_wdata), .Branch_en(Branch_en), .FLAG_OUT(FLAG_OUT),
    .Target(Target), .ProgState(ProgState), .Taken_cnt(Taken_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    int          cyc;
    logic        be;
    logic        fl;
    logic [9:0]  tg;
    logic [1:0]  st;
    logic [15:0] cn;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", nm, detail);
    end
  endtask

  // Monitor: compares every expectation scheduled for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc)
          check(e.name, 1'b0, $sformatf("expectation for cycle %0d never sampled", e.cyc));
        else
          check(e.name,
                Branch_en === e.be && FLAG_OUT === e.fl && Target === e.tg &&
                ProgState === e.st && Taken_cnt === e.cn,
                $sformatf("got be=%b fl=%b tg=%h st=%b cnt=%h, want be=%b fl=%b tg=%h st=%b cnt=%h",
                          Branch_en, FLAG_OUT, Target, ProgState, Taken_cnt,
                          e.be, e.fl, e.tg, e.st, e.cn));
      end
      if (done) begin
        check("queue_drained", q.size() == 0, $sformatf("%0d entries left", q.size()));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic be, input logic fl,
                            input logic [9:0] tg, input logic [1:0] st, input logic [15:0] cn);
    exp_t e;
    e.name = nm; e.cyc = cyc; e.be = be; e.fl = fl; e.tg = tg; e.st = st; e.cn = cn;
    q.push_back(e);
  endtask

  task automatic idle_in();
    Start = 0; Halt_in = 0; Cmp_en = 0; Br_req = 0; Lut_we = 0;
    Cmp_op = 2'b00; Cmp_a = 8'd0; Cmp_b = 8'd0;
  endtask

  task automatic cmp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    Cmp_en = 1; Cmp_op = op; Cmp_a = a; Cmp_b = b;
  endtask

  initial begin
    Init_n = 0; idle_in();
    Br_idx = 3'd3; Lut_waddr = 3'd0; Lut_wdata = 10'h0;

    step(); expect_out("reset", 0, 0, 10'h000, 2'b00, 16'd0);
    Init_n = 1;

    step(); Lut_we = 1; Lut_waddr = 3'd3; Lut_wdata = 10'h071;
    expect_out("lut_write_old", 0, 0, 10'h000, 2'b00, 16'd0);
    step(); idle_in(); Start = 1;
    expect_out("lut_written", 0, 0, 10'h071, 2'b00, 16'd0);
    step(); idle_in(); cmp(2'b00, 8'd5, 8'd5);
    expect_out("run_cmp_eq", 0, 0, 10'h071, 2'b01, 16'd0);
    step(); idle_in(); Br_req = 1;
    expect_out("branch_taken", 1, 1, 10'h071, 2'b01, 16'd0);
    step(); idle_in(); Br_req = 1; cmp(2'b10, 8'd9, 8'd2);
    expect_out("same_cycle_old_flag", 1, 1, 10'h071, 2'b01, 16'd1);
    step(); idle_in();
    expect_out("flag_updated", 0, 0, 10'h071, 2'b01, 16'd2);

    step(); idle_in(); Br_idx = 3'd2; Lut_we = 1; Lut_waddr = 3'd2; Lut_wdata = 10'h3FF;
    expect_out("rdw_old", 0, 0, 10'h000, 2'b01, 16'd2);
    step(); idle_in(); Br_req = 1;
    expect_out("rdw_new_flag0_branch", 1, 0, 10'h3FF, 2'b01, 16'd2);

    step(); idle_in(); Br_idx = 3'd3; Halt_in = 1; Start = 1; cmp(2'b11, 8'd0, 8'd0);
    expect_out("halt_req", 0, 0, 10'h071, 2'b01, 16'd2);
    step(); idle_in(); Br_req = 1; cmp(2'b00, 8'd1, 8'd2);
    expect_out("halted_no_branch", 0, 1, 10'h071, 2'b10, 16'd2);
    step(); idle_in(); Start = 1; Halt_in = 1;
    expect_out("halted_cmp_ignored", 0, 1, 10'h071, 2'b10, 16'd2);
    step(); idle_in(); Br_idx = 3'd2; cmp(2'b01, 8'd7, 8'd8);
    expect_out("restart_clears", 0, 0, 10'h3FF, 2'b01, 16'd0);

    step(); idle_in(); Br_req = 1; Halt_in = 1;
    expect_out("halt_with_branch", 1, 1, 10'h3FF, 2'b01, 16'd0);
    step(); idle_in();
    expect_out("halt_branch_counted", 0, 1, 10'h3FF, 2'b10, 16'd1);
    step(); idle_in(); Start = 1; Br_idx = 3'd3;
    step(); idle_in(); cmp(2'b00, 8'd4, 8'd4);
    expect_out("second_restart", 0, 0, 10'h071, 2'b01, 16'd0);

    for (int i = 0; i < 65535; i++) begin
      step(); idle_in(); Br_req = 1;
      if (i < 2 || i == 65534) expect_out($sformatf("count_%0d", i), 1, 1, 10'h071, 2'b01, 16'(i));
    end
    step(); idle_in(); Br_req = 1;
    expect_out("sat_reach", 1, 1, 10'h071, 2'b01, 16'hFFFF);
    step(); idle_in(); cmp(2'b10, 8'd9, 8'd2);
    expect_out("sat_hold", 0, 1, 10'h071, 2'b01, 16'hFFFF);
    step(); idle_in(); cmp(2'b11, 8'd0, 8'd0);
    expect_out("lt_false", 0, 0, 10'h071, 2'b01, 16'hFFFF);
    step(); idle_in();
    expect_out("ge_equal", 0, 1, 10'h071, 2'b01, 16'hFFFF);

    step(); idle_in(); Br_req = 1;
    #2 Init_n = 0;
    expect_out("async_reset", 0, 0, 10'h000, 2'b00, 16'd0);
    step(); step();
    done = 1'b1;
  end

endmodule
